mem_port_arbiter: RTL and testbench

- Shares one single-port, fixed-latency memory between the IF-stage fetch port and the MEM-stage load/store port of the 5-stage core.
- Sequences each access (grant, latency wait, response) and tells the pipeline which stage must stall.
- Data port has priority; an anti-starvation streak limit guarantees forward progress for fetch.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arb_prio.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/MEM memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    typedef enum logic {
        OWN_IF,
        OWN_D
    } owner_t;

    localparam logic [3:0] BE_WORD = 4'hF;

endpackage

// File: rtl/mem_arb_prio.sv
// Fetch/data grant selection with a data-streak limit so fetch always makes progress.
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int MaxStreak = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic arb_en,
    input  logic if_req,
    input  logic d_req,
    output logic grant_if,
    output logic grant_d
);

    localparam int SW = (MaxStreak < 1) ? 1 : $clog2(MaxStreak + 1);

    logic [SW-1:0] streak;
    logic          streak_hit;

    assign streak_hit = (streak == SW'(MaxStreak));

    // Data wins unless it has already taken MaxStreak grants in a row past a waiting fetch.
    assign grant_d  = arb_en & d_req & ~(if_req & streak_hit);
    assign grant_if = arb_en & if_req & ~grant_d;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            streak <= '0;
        end else if (grant_if) begin
            streak <= '0;
        end else if (grant_d) begin
            if (!if_req)
                streak <= '0;
            else if (!streak_hit)
                streak <= streak + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between fetch and load/store ports.
// Optional performance counters are built only when MEM_ARB_PERF_EN is defined.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int Width     = 32,
    parameter int AddrW     = 13,
    parameter int MemLat    = 2,
    parameter int MaxStreak = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             if_req_i,
    input  logic [AddrW-1:0] if_addr_i,
    input  logic             if_kill_i,
    output logic             if_gnt_o,
    output logic             if_rvalid_o,
    output logic [Width-1:0] if_rdata_o,
    input  logic             d_req_i,
    input  logic             d_we_i,
    input  logic [3:0]       d_be_i,
    input  logic [AddrW-1:0] d_addr_i,
    input  logic [Width-1:0] d_wdata_i,
    output logic             d_gnt_o,
    output logic             d_rvalid_o,
    output logic [Width-1:0] d_rdata_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [3:0]       mem_be_o,
    output logic [AddrW-1:0] mem_addr_o,
    output logic [Width-1:0] mem_wdata_o,
    input  logic [Width-1:0] mem_rdata_i,
    output logic             stall_if_o,
    output logic             stall_mem_o,
    output logic [31:0]      perf_conflict_o,
    output logic [31:0]      perf_if_wait_o
);

    localparam int LW = $clog2(MemLat + 1);

    state_t        state, state_nx;
    owner_t        owner, owner_nx;
    logic [LW-1:0] lat_cnt, lat_cnt_nx;
    logic          we_q, we_nx;
    logic          kill_q, kill_nx;
    logic          arb_en;
    logic          grant_if, grant_d;

    // Holding arbitration off during reset keeps every output quiet while rst_i is high.
    assign arb_en = (state == IDLE) & ~rst_i;

    mem_arb_prio #(
        .MaxStreak(MaxStreak)
    ) u_prio (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .arb_en  (arb_en),
        .if_req  (if_req_i),
        .d_req   (d_req_i),
        .grant_if(grant_if),
        .grant_d (grant_d)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            owner   <= OWN_IF;
            lat_cnt <= '0;
            we_q    <= 1'b0;
            kill_q  <= 1'b0;
        end else begin
            state   <= state_nx;
            owner   <= owner_nx;
            lat_cnt <= lat_cnt_nx;
            we_q    <= we_nx;
            kill_q  <= kill_nx;
        end
    end

    // NOTE: every signal gets a default first so no path through the case infers a latch.
    always_comb begin
        state_nx    = state;
        owner_nx    = owner;
        lat_cnt_nx  = lat_cnt;
        we_nx       = we_q;
        kill_nx     = kill_q;
        if_gnt_o    = grant_if;
        d_gnt_o     = grant_d;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if_rvalid_o = 1'b0;
        if_rdata_o  = '0;
        d_rvalid_o  = 1'b0;
        d_rdata_o   = '0;

        unique case (state)
            IDLE: begin
                if (grant_if || grant_d) begin
                    mem_req_o = 1'b1;
                    if (grant_d) begin
                        mem_we_o    = d_we_i;
                        mem_be_o    = d_be_i;
                        mem_addr_o  = d_addr_i;
                        mem_wdata_o = d_wdata_i;
                    end else begin
                        mem_be_o    = BE_WORD;
                        mem_addr_o  = if_addr_i;
                    end
                    owner_nx   = grant_d ? OWN_D : OWN_IF;
                    we_nx      = grant_d & d_we_i;
                    kill_nx    = 1'b0;
                    lat_cnt_nx = LW'(1);
                    state_nx   = (MemLat == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                lat_cnt_nx = lat_cnt + 1'b1;
                if (lat_cnt == LW'(MemLat - 1))
                    state_nx = RESP;
                if (owner == OWN_IF && if_kill_i)
                    kill_nx = 1'b1;
            end
            RESP: begin
                if (owner == OWN_D) begin
                    d_rvalid_o = 1'b1;
                    d_rdata_o  = we_q ? '0 : mem_rdata_i;
                end else if (!kill_q && !if_kill_i) begin
                    if_rvalid_o = 1'b1;
                    if_rdata_o  = mem_rdata_i;
                end
                kill_nx    = 1'b0;
                lat_cnt_nx = '0;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign stall_if_o  = if_req_i & ~if_rvalid_o;
    assign stall_mem_o = d_req_i & ~d_rvalid_o;

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_conflict_q, perf_if_wait_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_conflict_q <= '0;
            perf_if_wait_q  <= '0;
        end else begin
            if (state == IDLE && if_req_i && d_req_i && perf_conflict_q != '1)
                perf_conflict_q <= perf_conflict_q + 1'b1;
            if (stall_if_o && perf_if_wait_q != '1)
                perf_if_wait_q <= perf_if_wait_q + 1'b1;
        end
    end

    assign perf_conflict_o = perf_conflict_q;
    assign perf_if_wait_o  = perf_if_wait_q;
`else
    assign perf_conflict_o = '0;
    assign perf_if_wait_o  = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios, then random traffic vs a timeline model.
module tb_mem_port_arbiter;

    localparam int Width     = 32;
    localparam int AddrW     = 13;
    localparam int MemLat    = 2;
    localparam int MaxStreak = 4;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             if_req_i, if_kill_i;
    logic [AddrW-1:0] if_addr_i;
    logic             if_gnt_o, if_rvalid_o;
    logic [Width-1:0] if_rdata_o;
    logic             d_req_i, d_we_i;
    logic [3:0]       d_be_i;
    logic [AddrW-1:0] d_addr_i;
    logic [Width-1:0] d_wdata_i;
    logic             d_gnt_o, d_rvalid_o;
    logic [Width-1:0] d_rdata_o;
    logic             mem_req_o, mem_we_o;
    logic [3:0]       mem_be_o;
    logic [AddrW-1:0] mem_addr_o;
    logic [Width-1:0] mem_wdata_o, mem_rdata_i;
    logic             stall_if_o, stall_mem_o;
    logic [31:0]      perf_conflict_o, perf_if_wait_o;

    mem_port_arbiter #(
        .Width(Width), .AddrW(AddrW), .MemLat(MemLat), .MaxStreak(MaxStreak)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_kill_i(if_kill_i),
        .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_be_i(d_be_i), .d_addr_i(d_addr_i),
        .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
        .stall_if_o(stall_if_o), .stall_mem_o(stall_mem_o),
        .perf_conflict_o(perf_conflict_o), .perf_if_wait_o(perf_if_wait_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: one outstanding transaction on a cycle timeline plus a word memory.
    typedef struct {
        bit               active;
        bit               is_if;
        bit               we;
        logic [AddrW-1:0] addr;
        int               grant_c;
        int               resp_c;
        bit               killed;
    } txn_t;

    txn_t        txn;
    int          cyc = 0;
    int          streak = 0;
    logic [31:0] mem [int];
    logic [31:0] conflicts = 0;
    logic [31:0] if_waits = 0;
    bit          m_idle, m_resp, g_if_m, g_d_m, e_ifv, e_dv;
    bit          if_pend = 0, d_pend = 0;

    function automatic int widx(input logic [AddrW-1:0] a);
        return int'(a >> 2);
    endfunction

    function automatic logic [31:0] rd(input int w);
        if (mem.exists(w))
            return mem[w];
        return 32'h1357_0000 ^ (32'(w) * 32'h0000_9E37);
    endfunction

    task automatic eval();
        logic [31:0] exp_pc, exp_pw;
        if (txn.active && cyc == txn.resp_c)
            mem_rdata_i = rd(widx(txn.addr));
        else
            mem_rdata_i = $urandom;
        #1;
        if (rst_i) begin
            m_idle = 0; m_resp = 0; g_if_m = 0; g_d_m = 0; e_ifv = 0; e_dv = 0;
            check("rst_if_gnt", if_gnt_o, 0);
            check("rst_d_gnt", d_gnt_o, 0);
            check("rst_mem_req", mem_req_o, 0);
            check("rst_if_rvalid", if_rvalid_o, 0);
            check("rst_d_rvalid", d_rvalid_o, 0);
            check("rst_perf_conflict", perf_conflict_o, 0);
            check("rst_perf_if_wait", perf_if_wait_o, 0);
        end else begin
            m_idle = !txn.active;
            m_resp = txn.active && cyc == txn.resp_c;
            g_d_m  = m_idle && d_req_i && !(if_req_i && streak == MaxStreak);
            g_if_m = m_idle && if_req_i && !g_d_m;
            if (txn.active && txn.is_if && cyc > txn.grant_c && if_kill_i)
                txn.killed = 1;
            e_ifv = m_resp && txn.is_if && !txn.killed;
            e_dv  = m_resp && !txn.is_if;
            check("if_gnt", if_gnt_o, g_if_m);
            check("d_gnt", d_gnt_o, g_d_m);
            check("mem_req", mem_req_o, g_if_m | g_d_m);
            check("if_rvalid", if_rvalid_o, e_ifv);
            check("d_rvalid", d_rvalid_o, e_dv);
            check("stall_if", stall_if_o, if_req_i & ~e_ifv);
            check("stall_mem", stall_mem_o, d_req_i & ~e_dv);
            if (g_d_m) begin
                check("mem_we_d", mem_we_o, d_we_i);
                check("mem_be_d", mem_be_o, d_be_i);
                check("mem_addr_d", mem_addr_o, d_addr_i);
                check("mem_wdata_d", mem_wdata_o, d_wdata_i);
            end
            if (g_if_m) begin
                check("mem_we_if", mem_we_o, 0);
                check("mem_be_if", mem_be_o, 4'hF);
                check("mem_addr_if", mem_addr_o, if_addr_i);
            end
            if (e_ifv)
                check("if_rdata", if_rdata_o, rd(widx(txn.addr)));
            if (e_dv)
                check("d_rdata", d_rdata_o, txn.we ? 32'h0 : rd(widx(txn.addr)));
`ifdef MEM_ARB_PERF_EN
            exp_pc = conflicts;
            exp_pw = if_waits;
`else
            exp_pc = 0;
            exp_pw = 0;
`endif
            check("perf_conflict", perf_conflict_o, exp_pc);
            check("perf_if_wait", perf_if_wait_o, exp_pw);
        end
    endtask

    task automatic adv();
        logic [31:0] v;
        if (rst_i) begin
            txn.active = 0;
            streak = 0;
            conflicts = 0;
            if_waits = 0;
        end else begin
            if (m_idle && if_req_i && d_req_i) conflicts++;
            if (if_req_i && !e_ifv) if_waits++;
            if (m_resp) txn.active = 0;
            if (g_if_m || g_d_m) begin
                txn.active  = 1;
                txn.is_if   = g_if_m;
                txn.we      = g_d_m && d_we_i;
                txn.addr    = g_if_m ? if_addr_i : d_addr_i;
                txn.grant_c = cyc;
                txn.resp_c  = cyc + MemLat;
                txn.killed  = 0;
            end
            if (g_if_m) streak = 0;
            if (g_d_m) begin
                streak = if_req_i ? ((streak < MaxStreak) ? streak + 1 : MaxStreak) : 0;
                if (d_we_i) begin
                    v = rd(widx(d_addr_i));
                    for (int b = 0; b < 4; b++)
                        if (d_be_i[b]) v[8*b +: 8] = d_wdata_i[8*b +: 8];
                    mem[widx(d_addr_i)] = v;
                end
            end
        end
        cyc++;
        @(posedge clk_i);
        #1;
    endtask

    task automatic step();
        eval();
        adv();
    endtask

    task automatic gen();
        if (if_pend && $urandom_range(0, 19) == 0) if_pend = 0;
        if (!if_pend && $urandom_range(0, 2) == 0) begin
            if_pend = 1;
            if_addr_i = AddrW'($urandom);
        end
        if (!if_pend) if_addr_i = AddrW'($urandom);
        if_req_i = if_pend;
        if (!d_pend && $urandom_range(0, 2) == 0) begin
            d_pend    = 1;
            d_we_i    = 1'($urandom);
            d_be_i    = 4'($urandom);
            d_addr_i  = AddrW'($urandom);
            d_wdata_i = $urandom;
        end
        if (!d_pend) begin
            d_addr_i  = AddrW'($urandom);
            d_wdata_i = $urandom;
        end
        d_req_i   = d_pend;
        if_kill_i = ($urandom_range(0, 7) == 0);
    endtask

    int          gi;
    logic [31:0] init_word;

    initial begin
        txn.active = 0;
        rst_i = 1; if_req_i = 0; if_kill_i = 0; if_addr_i = '0;
        d_req_i = 0; d_we_i = 0; d_be_i = '0; d_addr_i = '0; d_wdata_i = '0; mem_rdata_i = '0;
        @(posedge clk_i);
        #1;

        // Reset state
        repeat (2) step();
        rst_i = 0;
        step();

        // Fetch alone
        mem[widx(13'h010)] = 32'h0050_0093;
        if_req_i = 1; if_addr_i = 13'h010;
        eval(); check("fetch_gnt_T", if_gnt_o, 1); check("fetch_stall_T", stall_if_o, 1); adv();
        eval(); check("fetch_stall_T1", stall_if_o, 1); check("fetch_rvalid_T1", if_rvalid_o, 0); adv();
        eval(); check("fetch_rvalid_T2", if_rvalid_o, 1); check("fetch_rdata_T2", if_rdata_o, 32'h0050_0093); adv();
        if_req_i = 0;
        step();

        // Store alone
        d_req_i = 1; d_we_i = 1; d_be_i = 4'b0011; d_addr_i = 13'h7F0; d_wdata_i = 32'h0000_BEEF;
        init_word = rd(widx(13'h7F0));
        eval(); check("store_we", mem_we_o, 1); check("store_be", mem_be_o, 4'b0011); adv();
        d_req_i = 0; d_we_i = 0;
        step();
        eval(); check("store_ack", d_rvalid_o, 1); check("store_rdata", d_rdata_o, 0); adv();
        step();

        // Both requesting continuously: D,D,D,D,IF pattern
        if_req_i = 1; if_addr_i = 13'h040;
        d_req_i = 1; d_we_i = 0; d_be_i = 4'hF; d_addr_i = 13'h080;
        gi = 0;
        for (int c = 0; c < 40 && gi < 10; c++) begin
            eval();
            if (if_gnt_o || d_gnt_o) begin
                check("streak_pattern", if_gnt_o, (gi % 5) == 4);
                gi++;
            end
            adv();
        end
        check("streak_grant_count", gi, 10);
        if_req_i = 0; d_req_i = 0;
        repeat (3) step();

        // Kill an outstanding fetch; pending data is granted at the next IDLE
        if_req_i = 1; if_addr_i = 13'h020;
        eval(); check("kill_fetch_gnt", if_gnt_o, 1); adv();
        if_req_i = 0; if_kill_i = 1;
        d_req_i = 1; d_we_i = 0; d_addr_i = 13'h100;
        step();
        if_kill_i = 0;
        eval(); check("kill_no_rvalid", if_rvalid_o, 0); adv();
        eval(); check("kill_then_d_gnt", d_gnt_o, 1); adv();
        d_req_i = 0;
        repeat (3) step();

        // Reset during WAIT of a load, then a clean load of the stored word
        d_req_i = 1; d_we_i = 0; d_addr_i = 13'h7F0;
        eval(); check("rst_load_gnt", d_gnt_o, 1); adv();
        d_req_i = 0;
        rst_i = 1;
        step();
        eval(); check("rst_no_d_rvalid", d_rvalid_o, 0); adv();
        rst_i = 0;
        step();
        d_req_i = 1;
        eval(); check("post_rst_gnt", d_gnt_o, 1); adv();
        d_req_i = 0;
        step();
        eval();
        check("post_rst_rvalid", d_rvalid_o, 1);
        check("post_rst_rdata", d_rdata_o, {init_word[31:16], 16'hBEEF});
        adv();

        // Random traffic against the model
        for (int c = 0; c < 800; c++) begin
            gen();
            eval();
            if (g_if_m) if_pend = 0;
            if (g_d_m) d_pend = 0;
            adv();
        end
        if_req_i = 0; d_req_i = 0; if_kill_i = 0;
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
